// File: rtl/sound_pkg.sv
// sound_pkg
// Shared widths, state encoding and sweep arithmetic for the sound path.
// beep_sequencer and tone_generator both use FREQ_W for the frequency code.
// A frequency code of 0 means silence.
package sound_pkg;

    localparam int FREQ_W = 9;   // frequency code width (tone_generator input)
    localparam int DUR_W  = 16;  // beep duration in ticks
    localparam int INT_W  = 8;   // ticks between sweep steps
    localparam int WRAP_W = 4;   // sweep restart count

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PLAY = 1'b1
    } beep_state_t;

    // Moves cur one step toward tgt and saturates at tgt. The intermediates
    // are one bit wider than the code, so neither an overflow on the way up
    // nor an underflow on the way down can happen.
    function automatic logic [FREQ_W-1:0] step_toward(
        input logic [FREQ_W-1:0] cur,
        input logic [FREQ_W-1:0] tgt,
        input logic [FREQ_W-1:0] step,
        input logic              up
    );
        logic [FREQ_W:0] w_cur;
        logic [FREQ_W:0] w_tgt;
        logic [FREQ_W:0] w_step;
        logic [FREQ_W:0] w_lim;
        w_cur  = {1'b0, cur};
        w_tgt  = {1'b0, tgt};
        w_step = {1'b0, step};
        if (up) begin
            w_lim = w_cur + w_step;
            if (w_lim > w_tgt) begin
                return tgt;
            end else begin
                return w_lim[FREQ_W-1:0];
            end
        end else begin
            w_lim = w_tgt + w_step;
            if (w_cur < w_lim) begin
                return tgt;
            end else begin
                return FREQ_W'(w_cur - w_step);
            end
        end
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler
// Divides the system clock down to the duration/sweep time base.
// The counter runs 0..TICK_DIV-1. tick is high for one clock on the last
// count, so the first tick comes TICK_DIV clocks after clear is released.
// Ports:
//   clk   in  system clock
//   reset in  synchronous, active-high reset
//   clear in  hold the counter at 0 (no tick while clear is high)
//   tick  out one-clock pulse on each counter wrap
module tick_prescaler #(
    parameter int TICK_DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    // Prescaler counter: wraps at TICK_DIV-1 and is held at 0 while cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (clear) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (r_cnt == LAST) begin
            r_cnt <= {CNT_W{1'b0}};
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign tick = (r_cnt == LAST) && !clear;

endmodule

// File: rtl/beep_sequencer.sv
// beep_sequencer
// Accepts one beep command at a time and drives the tone generator's
// frequency code over time: duration, linear pitch sweep from pitch1
// toward pitch2, and sweep restarts (wrap).
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   cmd_valid/ready   command handshake (ready only in IDLE)
//   cmd_pitch1/2      start / sweep end frequency codes
//   cmd_step          sweep increment (0 = no sweep)
//   cmd_interval      ticks between sweep steps (0 = no sweep)
//   cmd_duration      beep length in ticks (0 = play until stop)
//   cmd_wrap          restarts from pitch1 after reaching pitch2
//   stop              abort the current beep
//   freq              registered frequency code (0 = silence)
//   busy              high while playing
//   done              one-clock pulse when a beep ends (not on reset)
module beep_sequencer
    import sound_pkg::*;
#(
    parameter int CLK_HZ  = 27000000,
    parameter int TICK_HZ = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [FREQ_W-1:0] cmd_pitch1,
    input  logic [FREQ_W-1:0] cmd_pitch2,
    input  logic [FREQ_W-1:0] cmd_step,
    input  logic [INT_W-1:0]  cmd_interval,
    input  logic [DUR_W-1:0]  cmd_duration,
    input  logic [WRAP_W-1:0] cmd_wrap,
    input  logic              stop,
    output logic [FREQ_W-1:0] freq,
    output logic              busy,
    output logic              done
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;

    beep_state_t       r_state,    w_state_nxt;
    logic [FREQ_W-1:0] r_freq,     w_freq_nxt;
    logic              r_done,     w_done_nxt;
    logic [FREQ_W-1:0] r_pitch1,   w_pitch1_nxt;
    logic [FREQ_W-1:0] r_pitch2,   w_pitch2_nxt;
    logic [FREQ_W-1:0] r_step,     w_step_nxt;
    logic [INT_W-1:0]  r_interval, w_interval_nxt;
    logic [DUR_W-1:0]  r_duration, w_duration_nxt;
    logic [DUR_W-1:0]  r_dur_cnt,  w_dur_cnt_nxt;
    logic [INT_W-1:0]  r_int_cnt,  w_int_cnt_nxt;
    logic [WRAP_W-1:0] r_wrap_cnt, w_wrap_cnt_nxt;

    logic w_tick;
    logic w_presc_clr;
    logic w_sweep_en;
    logic w_dur_expire;

    // The time base only runs while playing, so it restarts at 0 on accept.
    assign w_presc_clr = (r_state != PLAY);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (w_presc_clr),
        .tick  (w_tick)
    );

    assign w_sweep_en   = (r_step != {FREQ_W{1'b0}}) && (r_interval != {INT_W{1'b0}})
                          && (r_pitch1 != r_pitch2);
    assign w_dur_expire = w_tick && (r_duration != {DUR_W{1'b0}})
                          && (r_dur_cnt == DUR_W'(1));

    // Next-state and next-output logic: stop beats expiry beats sweep step.
    always_comb begin
        w_state_nxt    = r_state;
        w_freq_nxt     = r_freq;
        w_done_nxt     = 1'b0;
        w_pitch1_nxt   = r_pitch1;
        w_pitch2_nxt   = r_pitch2;
        w_step_nxt     = r_step;
        w_interval_nxt = r_interval;
        w_duration_nxt = r_duration;
        w_dur_cnt_nxt  = r_dur_cnt;
        w_int_cnt_nxt  = r_int_cnt;
        w_wrap_cnt_nxt = r_wrap_cnt;
        case (r_state)
            IDLE: begin
                w_freq_nxt = {FREQ_W{1'b0}};
                if (cmd_valid) begin
                    w_state_nxt    = PLAY;
                    w_freq_nxt     = cmd_pitch1;
                    w_pitch1_nxt   = cmd_pitch1;
                    w_pitch2_nxt   = cmd_pitch2;
                    w_step_nxt     = cmd_step;
                    w_interval_nxt = cmd_interval;
                    w_duration_nxt = cmd_duration;
                    w_dur_cnt_nxt  = cmd_duration;
                    w_int_cnt_nxt  = cmd_interval;
                    w_wrap_cnt_nxt = cmd_wrap;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            PLAY: begin
                if (stop || w_dur_expire) begin
                    w_state_nxt = IDLE;
                    w_freq_nxt  = {FREQ_W{1'b0}};
                    w_done_nxt  = 1'b1;
                end else begin
                    if (w_tick && (r_duration != {DUR_W{1'b0}})) begin
                        w_dur_cnt_nxt = r_dur_cnt - DUR_W'(1);
                    end else begin
                        w_dur_cnt_nxt = r_dur_cnt;
                    end
                    if (w_tick && w_sweep_en) begin
                        if (r_int_cnt == INT_W'(1)) begin
                            w_int_cnt_nxt = r_interval;
                            if (r_freq == r_pitch2) begin
                                if (r_wrap_cnt != {WRAP_W{1'b0}}) begin
                                    w_freq_nxt     = r_pitch1;
                                    w_wrap_cnt_nxt = r_wrap_cnt - WRAP_W'(1);
                                end else begin
                                    w_freq_nxt = r_pitch2;
                                end
                            end else begin
                                // Direction is fixed by the endpoints, not by freq.
                                w_freq_nxt = step_toward(r_freq, r_pitch2, r_step,
                                                         r_pitch2 > r_pitch1);
                            end
                        end else begin
                            w_int_cnt_nxt = r_int_cnt - INT_W'(1);
                        end
                    end else begin
                        w_int_cnt_nxt = r_int_cnt;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_freq_nxt  = {FREQ_W{1'b0}};
            end
        endcase
    end

    // State and datapath registers; reset silences without a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_freq     <= {FREQ_W{1'b0}};
            r_done     <= 1'b0;
            r_pitch1   <= {FREQ_W{1'b0}};
            r_pitch2   <= {FREQ_W{1'b0}};
            r_step     <= {FREQ_W{1'b0}};
            r_interval <= {INT_W{1'b0}};
            r_duration <= {DUR_W{1'b0}};
            r_dur_cnt  <= {DUR_W{1'b0}};
            r_int_cnt  <= {INT_W{1'b0}};
            r_wrap_cnt <= {WRAP_W{1'b0}};
        end else begin
            r_state    <= w_state_nxt;
            r_freq     <= w_freq_nxt;
            r_done     <= w_done_nxt;
            r_pitch1   <= w_pitch1_nxt;
            r_pitch2   <= w_pitch2_nxt;
            r_step     <= w_step_nxt;
            r_interval <= w_interval_nxt;
            r_duration <= w_duration_nxt;
            r_dur_cnt  <= w_dur_cnt_nxt;
            r_int_cnt  <= w_int_cnt_nxt;
            r_wrap_cnt <= w_wrap_cnt_nxt;
        end
    end

    assign freq      = r_freq;
    assign done      = r_done;
    assign busy      = (r_state == PLAY);
    assign cmd_ready = (r_state == IDLE);

endmodule
